// File: rtl/rf_bypass_pkg.sv
// rtl/rf_bypass_pkg.sv - shared ISA constants: register file geometry and ALU op encodings
package rf_bypass_pkg;

   localparam int WIDTH  = 16;
   localparam int NREGS  = 8;
   localparam int REG_AW = $clog2(NREGS);

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SLL  = 3'd5,
      ALU_SRL  = 3'd6,
      ALU_PASS = 3'd7
   } alu_op_t;

endpackage

// File: rtl/rf_bypass_regfile_core.sv
// rtl/rf_bypass_regfile_core.sv - register storage with one write port and two raw read ports
module regfile_core
   import rf_bypass_pkg::*;
#(
   parameter int WIDTH = rf_bypass_pkg::WIDTH,
   parameter int NREGS = rf_bypass_pkg::NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2
);

   logic [WIDTH-1:0] regs [NREGS];

   // R0 is an ordinary register; no hardwired-zero special case
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/rf_bypass.sv
// rtl/rf_bypass.sv - register file with same-cycle writeback bypass and sticky X-detect flag
module rf_bypass
   import rf_bypass_pkg::*;
#(
   parameter int WIDTH = rf_bypass_pkg::WIDTH,
   parameter int NREGS = rf_bypass_pkg::NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    read1_reg,
   input  logic [AW-1:0]    read2_reg,
   input  logic [AW-1:0]    write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_en,
   output logic [WIDTH-1:0] read1_data,
   output logic [WIDTH-1:0] read2_data,
   output logic             err
);

   logic [WIDTH-1:0] core_rdata1;
   logic [WIDTH-1:0] core_rdata2;
   logic             hit1;
   logic             hit2;

   regfile_core #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (write_en),
      .waddr  (write_reg),
      .wdata  (write_data),
      .raddr1 (read1_reg),
      .raddr2 (read2_reg),
      .rdata1 (core_rdata1),
      .rdata2 (core_rdata2)
   );

   // Bypass stays live during reset; storage is already cleared, so a miss reads zero
   assign hit1 = write_en && (write_reg == read1_reg);
   assign hit2 = write_en && (write_reg == read2_reg);

   assign read1_data = hit1 ? write_data : core_rdata1;
   assign read2_data = hit2 ? write_data : core_rdata2;

`ifdef SYNTHESIS
   assign err = 1'b0;
`else
   logic err_q;
   logic wb_bad;

   // Read addresses are deliberately excluded: X there only corrupts the operand, not state
   assign wb_bad = ((write_en !== 1'b0) && (write_en !== 1'b1)) ||
                   ((write_en === 1'b1) && ($isunknown(write_reg) || $isunknown(write_data)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (wb_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule
